// File: rtl/odd_even_pkg.sv
// Shared constants, state encoding and helpers for the odd/even stream checker.
package odd_even_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned STRIDE     = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // First value of the sequence: 0 for even mode, 1 for odd mode.
    function automatic logic seq_start(input logic mode_even);
        return ~mode_even;
    endfunction

endpackage

// File: rtl/odd_even_expected_gen.sv
// Loadable expected-value register that advances by STRIDE, wrapping mod 2^DATA_W.
module odd_even_expected_gen
    import odd_even_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_val_i,
    input  logic              adv_i,
    output logic [DATA_W-1:0] value_o
);

    logic [DATA_W-1:0] value_q;
    logic [DATA_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (adv_i) begin
            value_d = value_q + DATA_W'(STRIDE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/odd_even_stream_checker.sv
// Checks a valid/ready stream against 0,2,4,.. or 1,3,5,.. and reports pass/fail.
// Optional CHECKER_ABORT_EN: end the burst on the first mismatching word.
module odd_even_stream_checker
    import odd_even_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode_even,
    input  logic [CNT_W-1:0]  exp_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  first_q, first_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic              accept_c;
    logic              mismatch_c;
    logic              exp_load_c;
    logic              exp_adv_c;
    logic [DATA_W-1:0] exp_val_c;
    logic [DATA_W-1:0] load_val_c;

    odd_even_expected_gen #(
        .DATA_W (DATA_W)
    ) u_exp (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (exp_load_c),
        .load_val_i (load_val_c),
        .adv_i      (exp_adv_c),
        .value_o    (exp_val_c)
    );

    assign accept_c   = in_valid & ready_q;
    assign mismatch_c = (in_data != exp_val_c);
    assign load_val_c = DATA_W'(seq_start(mode_even));

    // Next-state, counters and the registered-output decodes.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        err_d      = err_q;
        first_d    = first_q;
        pass_d     = pass_q;
        exp_load_c = 1'b0;
        exp_adv_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d    = exp_count;
                    idx_d      = '0;
                    err_d      = '0;
                    first_d    = ALL_ONES;
                    pass_d     = 1'b0;
                    exp_load_c = 1'b1;
                    state_d    = (exp_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    exp_adv_c = 1'b1;
                    idx_d     = idx_q + CNT_W'(1);
                    if (idx_q == count_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                    if (mismatch_c) begin
                        if (err_q != ALL_ONES) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        if (err_q == '0) begin
                            first_d = idx_q;
                        end
`ifdef CHECKER_ABORT_EN
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Verdict uses the updated error count so the final word is included.
        if (state_d == ST_DONE) begin
            pass_d = (err_d == '0);
        end

        ready_d = (state_d == ST_RUN);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            first_q <= ALL_ONES;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready      = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_odd_even_stream_checker.sv
// Scoreboard bench for odd_even_stream_checker: a driver issues bursts and queues
// the model's verdict; a monitor pops and compares on every done pulse.
module tb_odd_even_stream_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode_even = 1'b0;
    logic [7:0] exp_count = 8'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] first_err_idx;

    odd_even_stream_checker #(
        .DATA_W (8),
        .CNT_W  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode_even     (mode_even),
        .exp_count     (exp_count),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pass;
        logic [7:0] err;
        logic [7:0] first;
        int         nacc;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    logic [7:0] words[$];
    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         done_seen = 0;
    int         acc = 0;
    int         last_acc = 0;
    bit         prev_done = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference verdict: walk the expected arithmetic sequence over the burst's words.
    function automatic exp_t model(input bit mode, input int cnt);
        exp_t r;
        int   ev;
        r.pass  = 1'b0;
        r.err   = 8'd0;
        r.first = 8'hFF;
        r.nacc  = 0;
        for (int i = 0; i < cnt; i++) begin
            ev = ((mode ? 0 : 1) + 2 * i) % 256;
            r.nacc = r.nacc + 1;
            if (int'(words[i]) != ev) begin
                if (r.err == 8'd0) r.first = 8'(i);
                if (r.err != 8'hFF) r.err = r.err + 8'd1;
`ifdef CHECKER_ABORT_EN
                break;
`endif
            end
        end
        r.pass = (r.err == 8'd0);
        return r;
    endfunction

    task automatic make_words(input bit mode, input int cnt, input int err_pct);
        logic [7:0] v;
        words.delete();
        for (int i = 0; i < cnt; i++) begin
            v = 8'(((mode ? 0 : 1) + 2 * i) % 256);
            if (int'($urandom % 100) < err_pct) v = v ^ 8'(1 + $urandom % 255);
            words.push_back(v);
        end
    endtask

    // Monitor: counts accepts, checks each done pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc       = 0;
            prev_done = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                acc++;
                last_acc = cycle;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    cur = sb.pop_front();
                    chk("pass", int'(pass), int'(cur.pass));
                    chk("err_count", int'(err_count), int'(cur.err));
                    chk("first_err_idx", int'(first_err_idx), int'(cur.first));
                    chk("accepts", acc, cur.nacc);
                    if (cur.nacc > 0) chk("done_latency", cycle - last_acc, 1);
                    chk("busy_in_done", int'(busy), 1);
                    chk("ready_in_done", int'(in_ready), 0);
                end
                chk("done_one_cycle", int'(prev_done), 0);
                acc = 0;
                done_seen++;
            end
            prev_done = done;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, int'(in_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err"}, int'(err_count), 0);
        chk({tag, "_first"}, int'(first_err_idx), 255);
    endtask

    // Driver: entered and left at posedge+1; vmode 0=back-to-back, 1=toggle, 2=random.
    task automatic run_burst(input bit mode, input int cnt, input int vmode,
                             input bit ign, input int rst_after, input bit quick);
        exp_t e;
        int   i;
        int   cyc;
        int   ds0;
        bit   v;
        bit   ig_done;
        e = model(mode, cnt);
        if (rst_after < 0) sb.push_back(e);
        ds0       = done_seen;
        start     = 1'b1;
        mode_even = mode;
        exp_count = 8'(cnt);
        in_valid  = 1'b0;
        @(posedge clk); #1;
        start     = 1'b0;
        mode_even = 1'($urandom);
        exp_count = 8'($urandom);
        i = 0;
        cyc = 0;
        ig_done = 1'b0;
        while (i < e.nacc && cyc < 4000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = (($urandom % 3) != 0);
            endcase
            in_valid = v;
            in_data  = v ? words[i] : 8'($urandom);
            if (ign && i == 2 && !ig_done) begin
                start     = 1'b1;
                mode_even = ~mode;
                exp_count = 8'd3;
                ig_done   = 1'b1;
            end
            @(negedge clk);
            if (in_valid && in_ready) i++;
            if (rst_after >= 0 && i == rst_after) break;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        if (rst_after >= 0) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            start    = 1'b0;
            rst_n    = 1'b0;
            #1;
            chk_reset_vals("midrst");
            repeat (4) @(negedge clk);
            chk("midrst_no_done", done_seen - ds0, 0);
            rst_n = 1'b1;
            @(posedge clk); #1;
            return;
        end
        if (cyc >= 4000) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0d required=%0d", i, e.nacc);
        end
        in_valid = (e.nacc < cnt);
        if (e.nacc < cnt) in_data = words[e.nacc];
        cyc = 0;
        while (done_seen == ds0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_count", done_seen - ds0, 1);
        in_valid = 1'b0;
        if (!quick) begin
            repeat (3) @(posedge clk);
            #1;
            chk("pass_hold", int'(pass), int'(e.pass));
            chk("idle_ready", int'(in_ready), 0);
            chk("idle_busy", int'(busy), 0);
        end
    endtask

    initial begin
        bit m;
        int n;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        make_words(1'b1, 20, 0);
        run_burst(1'b1, 20, 0, 1'b0, -1, 1'b0);

        words = {8'd1, 8'd3, 8'd6, 8'd7, 8'd9};
        run_burst(1'b0, 5, 0, 1'b0, -1, 1'b0);

        make_words(1'b0, 130, 0);
        run_burst(1'b0, 130, 1, 1'b0, -1, 1'b0);

        words.delete();
        run_burst(1'b1, 0, 0, 1'b0, -1, 1'b0);

        make_words(1'b1, 10, 0);
        run_burst(1'b1, 10, 0, 1'b0, 3, 1'b0);
        make_words(1'b1, 4, 0);
        run_burst(1'b1, 4, 0, 1'b0, -1, 1'b0);

        make_words(1'b0, 10, 0);
        run_burst(1'b0, 10, 0, 1'b1, -1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            m = 1'($urandom);
            n = 1 + int'($urandom % 40);
            make_words(m, n, 10);
            run_burst(m, n, 2, 1'b0, -1, 1'($urandom));
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/odd_even_stream_checker.md
Name: odd_even_stream_checker

Overview:
Downstream consumer for the odd/even number generator stage. It accepts a valid/ready stream of generated values and checks each word against the expected sequence: 0,2,4,… in even mode or 1,3,5,… in odd mode. It counts mismatches and records the first failing index. It reports pass/fail through a one-cycle done pulse, so generator output is self-checked in hardware instead of by printout.

Parameters:
DATA_W, 8, width of streamed values and the expected-value register (wraps mod 2^DATA_W)
CNT_W, 8, width of the burst length, the index counter and the error counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a check burst; sampled only in IDLE
mode_even  input  1  expected parity: 1 = even sequence, 0 = odd sequence; latched on start
exp_count  input  CNT_W  number of words to check; latched on start
in_valid  input  1  upstream word valid
in_data  input  DATA_W  upstream word
in_ready  output  1  checker can accept a word
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse at burst end
pass  output  1  1 when the last burst had zero errors; held until the next start
err_count  output  CNT_W  mismatches in the current/last burst; saturates at all-ones
first_err_idx  output  CNT_W  index of the first mismatch; all-ones if there was none

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready=0, busy=0, done=0, pass=0.
  - err_count=0, first_err_idx=all-ones, index=0, expected=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - latch mode_even and exp_count; expected <= mode_even ? 0 : 1.
  - index <= 0; err_count <= 0; first_err_idx <= all-ones; pass <= 0.
- IDLE -> DONE on start=1 with exp_count=0: no words are accepted; pass=1 in the DONE cycle.
- in_ready is a registered-state decode: 1 only in RUN. A word is accepted on a rising edge with in_valid & in_ready.
- On each accept:
  - if in_data != expected: err_count increments (saturating); if this is the first error, first_err_idx <= index.
  - expected <= expected + 2, truncated to DATA_W so it wraps (odd: 255 -> 1 at DATA_W=8).
  - index <= index + 1.
- RUN -> DONE on the accept where index == latched count-1.
- Without an accept, RUN holds indefinitely; there is no timeout.
- DONE lasts exactly one cycle, then returns to IDLE:
  - done=1; pass = (err_count==0), including the final word's result (next-state compare).
  - in_ready=0.
- start while in RUN or DONE is ignored. start in the IDLE cycle immediately after DONE is honoured.
- in_data is don't-care when in_valid=0. in_valid toggling mid-burst only stalls progress.
- Reset asserted mid-burst aborts immediately to reset values. No done pulse is produced.

Optional Feature:
Macro CHECKER_ABORT_EN.
- Defined: on the first mismatching accept, the FSM goes RUN -> DONE on that same edge regardless of the remaining count. done pulses the next cycle with pass=0, err_count=1, first_err_idx = failing index. No further words are accepted.
- Undefined: the full burst is always consumed and all errors are counted.

Decomposition:
- Shared package odd_even_pkg:
  - state enum type (IDLE/RUN/DONE).
  - default DATA_W/CNT_W constants.
  - function for the sequence start value from mode_even (0/1).
  - STRIDE constant = 2.
- Optional sub-module odd_even_expected_gen: loadable expected-value register that advances by STRIDE on an enable.

Test Plan:
- Even pass: start, mode_even=1, exp_count=20; feed 0,2,…,38 back-to-back -> 20 accepts, done pulses 1 cycle after the 20th accept, pass=1, err_count=0, first_err_idx=255.
- Odd with error: mode_even=0, exp_count=5; feed 1,3,6,7,9 -> done, pass=0, err_count=1, first_err_idx=2; with CHECKER_ABORT_EN, done after the 3rd word and the 4th word is never accepted (in_ready=0).
- Backpressure and wrap: odd mode, exp_count=130, in_valid toggling every other cycle; values wrap 255 -> 1 -> pass=1, 130 accepts.
- Zero count: start with exp_count=0 -> DONE on the next cycle, done=1, pass=1, in_ready never asserted.
- Reset mid-burst: assert rst_n=0 after 3 of 10 words -> all outputs at reset values, no done. A new start with even mode and 4 correct words -> pass=1.
- Ignored start: pulse start during RUN with different mode/count -> the original burst completes unchanged with its original result.
